// File: rtl/fir_out_pkg.sv
// Shared types and the rounding requantiser for the FIR output stage.
// Saturation is enabled by the FIR_OUT_SAT_EN macro in fir_out_requant.
package fir_out_pkg;

    localparam int CNT_WIDTH     = 32;
    localparam int SAT_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Round-half-up arithmetic right shift, kept at 33 bits so the
    // rounding add can never overflow.
    function automatic logic signed [32:0] requant(
        input logic signed [31:0] data,
        input logic        [4:0]  shift
    );
        logic signed [32:0] v;
        v = {data[31], data};
        if (shift != 5'd0)
            v = v + (33'sd1 <<< (shift - 5'd1));
        return v >>> shift;
    endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous FIFO with registered storage; output reads zero while empty.
// No read-to-write bypass: a full FIFO refuses writes even on a read.
module fir_out_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8
) (
    input  logic             axis_clk,
    input  logic             axis_rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             wr_ok;
    logic             rd_ok;

    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;

    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge axis_clk) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/fir_out_requant.sv
// FIR output requantiser: rounding shift, frame-length policing, output FIFO.
// Define FIR_OUT_SAT_EN to clamp out-of-range samples instead of wrapping.
module fir_out_requant
    import fir_out_pkg::*;
#(
    parameter int OUT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                     axis_clk,
    input  logic                     axis_rst_n,
    input  logic                     cfg_start,
    input  logic [31:0]              cfg_length,
    input  logic [4:0]               cfg_shift,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic [31:0]              s_tdata,
    input  logic                     s_tlast,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [OUT_WIDTH-1:0]     m_tdata,
    output logic                     m_tlast,
    output logic                     busy,
    output logic                     done,
    output logic                     err_early,
    output logic                     err_late,
    output logic [SAT_CNT_WIDTH-1:0] sat_cnt
);

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_WIDTH-1:0]   len_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [4:0]             shift_q;
    logic signed [32:0]     rq;
    logic [OUT_WIDTH-1:0]   q_data;
    logic                   q_sat;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   start_ok;
    logic                   in_hs;
    logic                   out_hs;
    logic                   hit_len;
    logic                   end_frame;

    assign start_ok  = cfg_start & ((state == ST_IDLE) | (state == ST_DONE));
    assign s_tready  = (state == ST_RUN) & ~fifo_full;
    assign in_hs     = s_tvalid & s_tready;
    assign m_tvalid  = ~fifo_empty;
    assign out_hs    = m_tvalid & m_tready;
    assign hit_len   = ((cnt_q + CNT_WIDTH'(1)) == len_q);
    assign end_frame = s_tlast | hit_len;
    assign busy      = (state == ST_RUN) | (state == ST_DRAIN);

    assign rq = requant(s_tdata, shift_q);

`ifdef FIR_OUT_SAT_EN
    logic [32-OUT_WIDTH+1:0] hi_bits;
    assign hi_bits = rq[32:OUT_WIDTH-1];
    // Out of range whenever the bits above the new sign bit disagree.
    assign q_sat   = ~(&hi_bits | ~|hi_bits);
    assign q_data  = !q_sat ? rq[OUT_WIDTH-1:0] :
                     rq[32] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} :
                              {1'b0, {(OUT_WIDTH-1){1'b1}}};
`else
    assign q_sat  = 1'b0;
    assign q_data = rq[OUT_WIDTH-1:0];
`endif

    fir_out_fifo #(
        .WIDTH (OUT_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .wr_en      (in_hs),
        .wr_data    ({end_frame, q_data}),
        .rd_en      (m_tready),
        .rd_data    ({m_tlast, m_tdata}),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE:
                if (cfg_start)
                    state_nxt = (cfg_length == '0) ? ST_DONE : ST_RUN;
            ST_RUN:
                if (in_hs && end_frame)
                    state_nxt = ST_DRAIN;
            ST_DRAIN:
                if (out_hs && m_tlast)
                    state_nxt = ST_DONE;
            default:
                state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            len_q     <= '0;
            cnt_q     <= '0;
            shift_q   <= '0;
            done      <= 1'b0;
            err_early <= 1'b0;
            err_late  <= 1'b0;
            sat_cnt   <= '0;
        end else if (start_ok) begin
            len_q     <= cfg_length;
            shift_q   <= cfg_shift;
            cnt_q     <= '0;
            done      <= (cfg_length == '0);
            err_early <= 1'b0;
            err_late  <= 1'b0;
            sat_cnt   <= '0;
        end else begin
            if (in_hs) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
                if (s_tlast && !hit_len)
                    err_early <= 1'b1;
                if (hit_len && !s_tlast)
                    err_late <= 1'b1;
                if (q_sat && (sat_cnt != '1))
                    sat_cnt <= sat_cnt + SAT_CNT_WIDTH'(1);
            end
            if ((state == ST_DRAIN) && out_hs && m_tlast)
                done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed bench for fir_out_requant: requant vectors plus frame corner cases.
// Expectations follow FIR_OUT_SAT_EN when it is defined for the build.
module tb_fir_out_requant;

    localparam int W = 16;

`ifdef FIR_OUT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          axis_clk = 1'b0;
    logic          axis_rst_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic [31:0]   cfg_length = '0;
    logic [4:0]    cfg_shift = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [31:0]   s_tdata = '0;
    logic          s_tlast = 1'b0;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic [W-1:0]  m_tdata;
    logic          m_tlast;
    logic          busy;
    logic          done;
    logic          err_early;
    logic          err_late;
    logic [15:0]   sat_cnt;

    fir_out_requant #(
        .OUT_WIDTH  (W),
        .FIFO_DEPTH (8)
    ) dut (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .cfg_start  (cfg_start),
        .cfg_length (cfg_length),
        .cfg_shift  (cfg_shift),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tdata    (s_tdata),
        .s_tlast    (s_tlast),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast),
        .busy       (busy),
        .done       (done),
        .err_early  (err_early),
        .err_late   (err_late),
        .sat_cnt    (sat_cnt)
    );

    always #5 axis_clk = ~axis_clk;

    int checks = 0;
    int errors = 0;
    int n_acc = 0;
    logic [W:0] q[$];

    // Inputs change just after posedge, so negedge sees the next edge's values.
    always @(negedge axis_clk)
        if (axis_rst_n && m_tvalid && m_tready)
            q.push_back({m_tlast, m_tdata});

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] len, input logic [4:0] sh);
        cfg_length = len;
        cfg_shift  = sh;
        cfg_start  = 1'b1;
        @(posedge axis_clk); #1;
        cfg_start  = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input logic l,
                        input int lim, output bit ok);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge axis_clk);
            if (s_tready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge axis_clk); #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (ok)
            n_acc++;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        bit ok;
        push(d, l, 100, ok);
        chk("push_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge axis_clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk(nm, 32'(seen), 32'd1);
        @(posedge axis_clk); #1;
    endtask

    task automatic check_q(input string nm, input logic [W-1:0] d,
                           input logic l);
        logic [W:0] it;
        chk({nm, "_avail"}, 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
            it = q.pop_front();
            chk({nm, "_data"}, 32'(it[W-1:0]), 32'(d));
            chk({nm, "_last"}, 32'(it[W]), 32'(l));
        end
    endtask

    typedef struct {
        logic [31:0]  data;
        logic [4:0]   shift;
        logic [W-1:0] wrap;
        logic [W-1:0] sat;
        logic         satf;
    } vec_t;

    vec_t tv[12];

    initial begin
        tv[0]  = '{32'd100,        5'd4,  16'h0006, 16'h0006, 1'b0};
        tv[1]  = '{32'hFFFFFF9C,   5'd4,  16'hFFFA, 16'hFFFA, 1'b0};
        tv[2]  = '{32'd7,          5'd4,  16'h0000, 16'h0000, 1'b0};
        tv[3]  = '{32'h00012345,   5'd0,  16'h2345, 16'h7FFF, 1'b1};
        tv[4]  = '{32'hFFFF0000,   5'd0,  16'h0000, 16'h8000, 1'b1};
        tv[5]  = '{32'h7FFFFFFF,   5'd31, 16'h0001, 16'h0001, 1'b0};
        tv[6]  = '{32'h80000000,   5'd31, 16'hFFFF, 16'hFFFF, 1'b0};
        tv[7]  = '{32'd24,         5'd3,  16'h0003, 16'h0003, 1'b0};
        tv[8]  = '{32'hFFFFFFE8,   5'd3,  16'hFFFD, 16'hFFFD, 1'b0};
        tv[9]  = '{32'h00100000,   5'd4,  16'h0000, 16'h7FFF, 1'b1};
        tv[10] = '{32'h0007FFF0,   5'd4,  16'h7FFF, 16'h7FFF, 1'b0};
        tv[11] = '{32'hFFF80000,   5'd4,  16'h8000, 16'h8000, 1'b0};

        repeat (3) @(posedge axis_clk);
        #1 axis_rst_n = 1'b1;
        @(negedge axis_clk);
        chk("rst_s_tready", 32'(s_tready), 0);
        chk("rst_m_tvalid", 32'(m_tvalid), 0);
        chk("rst_m_tdata", 32'(m_tdata), 0);
        chk("rst_m_tlast", 32'(m_tlast), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_errs", {err_early, err_late}, 0);
        chk("rst_sat", 32'(sat_cnt), 0);
        @(posedge axis_clk); #1;

        for (int i = 0; i < 12; i++) begin
            q.delete();
            do_start(1, tv[i].shift);
            send(tv[i].data, 1'b1);
            wait_done($sformatf("vec%0d_done", i));
            check_q($sformatf("vec%0d", i), SAT ? tv[i].sat : tv[i].wrap, 1'b1);
            chk($sformatf("vec%0d_sat", i), 32'(sat_cnt), SAT ? 32'(tv[i].satf) : 0);
            chk($sformatf("vec%0d_err", i), {err_early, err_late}, 0);
        end

        // Basic frame; a start pulse mid-run must be ignored.
        q.delete();
        do_start(3, 4);
        chk("a_busy", 32'(busy), 1);
        send(32'd100, 1'b0);
        do_start(1, 0);
        send(32'hFFFFFF9C, 1'b0);
        send(32'd7, 1'b1);
        wait_done("a_done");
        check_q("a0", 16'h0006, 1'b0);
        check_q("a1", 16'hFFFA, 1'b0);
        check_q("a2", 16'h0000, 1'b1);
        chk("a_err", {err_early, err_late}, 0);
        chk("a_busy_end", 32'(busy), 0);

        // Two saturating samples in one frame.
        q.delete();
        do_start(2, 0);
        send(32'h00012345, 1'b0);
        chk("b_sat1", 32'(sat_cnt), SAT ? 1 : 0);
        send(32'hFFFF0000, 1'b1);
        wait_done("b_done");
        check_q("b0", SAT ? 16'h7FFF : 16'h2345, 1'b0);
        check_q("b1", SAT ? 16'h8000 : 16'h0000, 1'b1);
        chk("b_sat2", 32'(sat_cnt), SAT ? 2 : 0);

        // Early tlast.
        q.delete();
        do_start(5, 0);
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        send(32'd3, 1'b1);
        wait_done("c_done");
        check_q("c0", 16'd1, 1'b0);
        check_q("c1", 16'd2, 1'b0);
        check_q("c2", 16'd3, 1'b1);
        chk("c_extra", 32'(q.size()), 0);
        chk("c_err_early", 32'(err_early), 1);
        chk("c_err_late", 32'(err_late), 0);

        // Missing tlast: forced on the length-th sample, 5th refused.
        begin
            bit ok5;
            q.delete();
            do_start(4, 0);
            send(32'd10, 1'b0);
            send(32'd11, 1'b0);
            send(32'd12, 1'b0);
            send(32'd13, 1'b0);
            push(32'd14, 1'b0, 5, ok5);
            chk("d_5th_refused", 32'(ok5), 0);
            wait_done("d_done");
            check_q("d0", 16'd10, 1'b0);
            check_q("d1", 16'd11, 1'b0);
            check_q("d2", 16'd12, 1'b0);
            check_q("d3", 16'd13, 1'b1);
            chk("d_err_late", 32'(err_late), 1);
            chk("d_err_early", 32'(err_early), 0);
        end

        // Zero length finishes immediately without error.
        do_start(0, 0);
        chk("z_done", 32'(done), 1);
        chk("z_busy", 32'(busy), 0);
        chk("z_tready", 32'(s_tready), 0);
        chk("z_err", {err_early, err_late}, 0);

        // Backpressure: FIFO of 8 fills, then drains in order.
        q.delete();
        do_start(10, 0);
        m_tready = 1'b0;
        n_acc = 0;
        fork
            begin
                bit okf;
                bit all_ok;
                all_ok = 1'b1;
                for (int i = 1; i <= 10; i++) begin
                    push(32'(i), i == 10, 200, okf);
                    all_ok &= okf;
                end
                chk("e_all_accepted", 32'(all_ok), 1);
            end
            begin
                repeat (20) @(negedge axis_clk);
                chk("e_acc8", 32'(n_acc), 8);
                chk("e_tready_low", 32'(s_tready), 0);
                chk("e_no_out", 32'(q.size()), 0);
                chk("e_hold_valid", 32'(m_tvalid), 1);
                chk("e_hold_data", 32'(m_tdata), 1);
                chk("e_hold_last", 32'(m_tlast), 0);
                @(posedge axis_clk); #1;
                m_tready = 1'b1;
            end
        join
        wait_done("e_done");
        chk("e_count", 32'(q.size()), 10);
        for (int i = 1; i <= 10; i++)
            check_q($sformatf("e%0d", i), 16'(i), i == 10);

        // Reset mid-frame, then a clean frame.
        q.delete();
        m_tready = 1'b0;
        do_start(5, 0);
        send(32'd21, 1'b0);
        send(32'd22, 1'b0);
        axis_rst_n = 1'b0;
        @(negedge axis_clk);
        chk("f_tready", 32'(s_tready), 0);
        chk("f_m_tvalid", 32'(m_tvalid), 0);
        chk("f_m_tdata", 32'(m_tdata), 0);
        chk("f_m_tlast", 32'(m_tlast), 0);
        chk("f_busy", 32'(busy), 0);
        chk("f_done", 32'(done), 0);
        chk("f_errs", {err_early, err_late}, 0);
        chk("f_sat", 32'(sat_cnt), 0);
        @(posedge axis_clk); #1;
        axis_rst_n = 1'b1;
        m_tready = 1'b1;
        @(negedge axis_clk);
        chk("f_empty_after", 32'(m_tvalid), 0);
        @(posedge axis_clk); #1;
        q.delete();
        do_start(2, 0);
        send(32'd31, 1'b0);
        send(32'd32, 1'b1);
        wait_done("f_done2");
        check_q("f0", 16'd31, 1'b0);
        check_q("f1", 16'd32, 1'b1);
        chk("f_extra", 32'(q.size()), 0);
        chk("f_err2", {err_early, err_late}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
